// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
// The master side is the pipeline (drives control/register info, consumes
// stall/flush/forward selects); the slave side is the hazard scoreboard unit.
interface hazard_scoreboard_unit_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 32
);
  // D-stage control flow and long-op issue info
  logic          branchD;
  logic          jumpD;
  logic          jalrD;
  logic          br_takenD;
  logic          longopD;
  logic          regwriteD;
  logic [AW-1:0] writeregD;

  // Long-op (MUL/DIV) unit status
  logic          longop_busy;
  logic          longop_done;
  logic [AW-1:0] longop_tag;

  // E/M/W control
  logic          memtoregE;
  logic          regwriteE;
  logic          memtoregM;
  logic          regwriteM;
  logic          regwriteW;

  // Register specifiers
  logic [AW-1:0] rsD;
  logic [AW-1:0] rtD;
  logic [AW-1:0] rsE;
  logic [AW-1:0] rtE;
  logic [AW-1:0] writeregE;
  logic [AW-1:0] writeregM;
  logic [AW-1:0] writeregW;

  // Bypass selects
  logic          forwardAD;
  logic          forwardBD;
  logic [1:0]    forwardAE;
  logic [1:0]    forwardBE;

  // Pipeline stalls and flushes
  logic          stallF;
  logic          stallD;
  logic          stallE;
  logic          stallM;
  logic          stallW;
  logic          flushF;
  logic          flushD;
  logic          flushE;
  logic          flushM;
  logic          flushW;

  // Debug / performance
  logic [NREG-1:0] pending;
  logic [CW-1:0]   stall_cnt;

  modport master (
    output branchD, jumpD, jalrD, br_takenD, longopD, regwriteD, writeregD,
    output longop_busy, longop_done, longop_tag,
    output memtoregE, regwriteE, memtoregM, regwriteM, regwriteW,
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushF, flushD, flushE, flushM, flushW,
    input  pending, stall_cnt
  );

  modport slave (
    input  branchD, jumpD, jalrD, br_takenD, longopD, regwriteD, writeregD,
    input  longop_busy, longop_done, longop_tag,
    input  memtoregE, regwriteE, memtoregM, regwriteM, regwriteW,
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output forwardAD, forwardBD, forwardAE, forwardBE,
    output stallF, stallD, stallE, stallM, stallW,
    output flushF, flushD, flushE, flushM, flushW,
    output pending, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard / forwarding unit for the 5-stage pipe with a per-register
// scoreboard tracking destinations of in-flight variable-latency long ops.
// All outputs are combinational from the current inputs plus the registered
// scoreboard and stall counter.
module hazard_scoreboard_unit #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 32
) (
  input logic                     clk,
  input logic                     reset,
  hazard_scoreboard_unit_if.slave hz
);

  // E-stage bypass select: M result beats a completing long op, which beats W.
  // Register 0 never forwards.
  function automatic logic [1:0] fwd_e(
    input logic [AW-1:0] r,
    input logic [AW-1:0] wreg_m,
    input logic          rw_m,
    input logic          done,
    input logic [AW-1:0] tag,
    input logic [AW-1:0] wreg_w,
    input logic          rw_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (r != '0) begin
      if (rw_m && (r == wreg_m))      sel = 2'b10;
      else if (done && (tag == r))    sel = 2'b11;
      else if (rw_w && (r == wreg_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;
  logic [CW-1:0]     stall_cnt_q;
  logic [CW-1:0]     stall_cnt_d;
  logic [2**AW-1:0]  pend_full;

  logic lwstall;
  logic branchstall;
  logic sbstall;
  logic structstall;
  logic stall;
  logic issue;

  // Zero-extend the scoreboard to the full address space so any specifier
  // above NREG-1 reads as "not pending" without an out-of-range index.
  always_comb begin
    pend_full              = '0;
    pend_full[NREG-1:0]    = pending_q;
  end

  // Stall sources and the combined stall / issue decision.
  always_comb begin
    lwstall     = hz.memtoregE &&
                  ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
    branchstall = (hz.branchD || hz.jalrD) &&
                  ((hz.regwriteE && ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
                   (hz.memtoregM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
    // RAW on either source, or WAW against an in-flight long op destination
    sbstall     = ((hz.rsD != '0) && pend_full[hz.rsD]) ||
                  ((hz.rtD != '0) && pend_full[hz.rtD]) ||
                  (hz.regwriteD && (hz.writeregD != '0) && pend_full[hz.writeregD]);
    structstall = hz.longopD && hz.longop_busy;
    stall       = lwstall || branchstall || sbstall || structstall;
    issue       = hz.longopD && hz.regwriteD && (hz.writeregD != '0) && !stall;
  end

  // Per-register scoreboard next state; an issue to a register wins over a
  // same-cycle completion on it. Bit 0 can never set since issue excludes x0.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    assign pending_d[gi] = (issue && (hz.writeregD == AW'(gi))) ||
                           (pending_q[gi] && !(hz.longop_done && (hz.longop_tag == AW'(gi))));
  end

  // Stall-cycle counter wraps naturally at 2^CW.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + CW'(1);
  end

  // State registers with synchronous reset; flushes never touch the scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Forwarding, stall and flush outputs.
  always_comb begin
    hz.forwardAE = fwd_e(hz.rsE, hz.writeregM, hz.regwriteM, hz.longop_done,
                         hz.longop_tag, hz.writeregW, hz.regwriteW);
    hz.forwardBE = fwd_e(hz.rtE, hz.writeregM, hz.regwriteM, hz.longop_done,
                         hz.longop_tag, hz.writeregW, hz.regwriteW);
    hz.forwardAD = (hz.rsD != '0) && (hz.rsD == hz.writeregM) && hz.regwriteM;
    hz.forwardBD = (hz.rtD != '0) && (hz.rtD == hz.writeregM) && hz.regwriteM;

    hz.stallF    = stall;
    hz.stallD    = stall;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.stallW    = 1'b0;

    hz.flushF    = 1'b0;
    // A jump redirects unconditionally; branch/jalr only once operands are ready
    hz.flushD    = (hz.br_takenD && !stall) || hz.jumpD || (hz.jalrD && !stall);
    hz.flushE    = stall;
    hz.flushM    = 1'b0;
    hz.flushW    = 1'b0;

    hz.pending   = pending_q;
    hz.stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: a vector table for the
// combinational forwarding/stall/flush rules, then hand sequences for the
// scoreboard, reset and stall counter wrap (counter built 4 bits wide).
module tb_hazard_scoreboard_unit;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int NV   = 19;

  logic clk;
  logic reset;

  hazard_scoreboard_unit_if #(.NREG(NREG), .AW(AW), .CW(CW)) hz ();

  hazard_scoreboard_unit #(.NREG(NREG), .AW(AW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       branchD, jumpD, jalrD, br_takenD, longopD, regwriteD;
    logic       longop_busy, longop_done;
    logic       memtoregE, regwriteE, memtoregM, regwriteM, regwriteW;
    logic [4:0] writeregD, longop_tag, rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic [1:0] fae, fbe;
    logic       fad, fbd, stl, fld;
  } vec_t;

  vec_t tbl [NV];

  int n_cmp;
  int n_bad;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic clr();
    hz.branchD = 0; hz.jumpD = 0; hz.jalrD = 0; hz.br_takenD = 0;
    hz.longopD = 0; hz.regwriteD = 0; hz.writeregD = 0;
    hz.longop_busy = 0; hz.longop_done = 0; hz.longop_tag = 0;
    hz.memtoregE = 0; hz.regwriteE = 0; hz.memtoregM = 0; hz.regwriteM = 0; hz.regwriteW = 0;
    hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
    hz.writeregE = 0; hz.writeregM = 0; hz.writeregW = 0;
  endtask

  task automatic apply(input vec_t v);
    hz.branchD = v.branchD; hz.jumpD = v.jumpD; hz.jalrD = v.jalrD; hz.br_takenD = v.br_takenD;
    hz.longopD = v.longopD; hz.regwriteD = v.regwriteD; hz.writeregD = v.writeregD;
    hz.longop_busy = v.longop_busy; hz.longop_done = v.longop_done; hz.longop_tag = v.longop_tag;
    hz.memtoregE = v.memtoregE; hz.regwriteE = v.regwriteE; hz.memtoregM = v.memtoregM;
    hz.regwriteM = v.regwriteM; hz.regwriteW = v.regwriteW;
    hz.rsD = v.rsD; hz.rtD = v.rtD; hz.rsE = v.rsE; hz.rtE = v.rtE;
    hz.writeregE = v.writeregE; hz.writeregM = v.writeregM; hz.writeregW = v.writeregW;
  endtask

  // Check stallF/stallD/flushE for the current cycle and advance the counter model.
  task automatic cyc(input logic exp_st, input string nm);
    #1;
    chk({nm, ".stallD"}, 0, 32'(hz.stallD), 32'(exp_st));
    chk({nm, ".stallF"}, 0, 32'(hz.stallF), 32'(exp_st));
    chk({nm, ".flushE"}, 0, 32'(hz.flushE), 32'(exp_st));
    $display("seq %s: stall=%0b pending=%08h cnt=%0d", nm, hz.stallD, hz.pending, hz.stall_cnt);
    if (exp_st) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_cnt = '0;

    // Expected values below are worked out by hand from the hazard rules.
    tbl[0]  = '{default:'0};
    tbl[1]  = '{rsE:5'd3, writeregM:5'd3, regwriteM:1'b1, rsD:5'd3, fae:2'b10, fad:1'b1, default:'0};
    tbl[2]  = '{rsE:5'd3, writeregM:5'd3, regwriteM:1'b1, longop_done:1'b1, longop_tag:5'd3,
                writeregW:5'd3, regwriteW:1'b1, fae:2'b10, default:'0};
    tbl[3]  = '{rtE:5'd7, longop_done:1'b1, longop_tag:5'd7, fbe:2'b11, default:'0};
    tbl[4]  = '{rtE:5'd7, longop_done:1'b1, longop_tag:5'd7, writeregM:5'd7, regwriteM:1'b1,
                rtD:5'd7, fbe:2'b10, fbd:1'b1, default:'0};
    tbl[5]  = '{rtE:5'd7, longop_done:1'b1, longop_tag:5'd7, writeregW:5'd7, regwriteW:1'b1,
                fbe:2'b11, default:'0};
    tbl[6]  = '{rsE:5'd4, writeregW:5'd4, regwriteW:1'b1, fae:2'b01, default:'0};
    tbl[7]  = '{rsE:5'd0, writeregM:5'd0, regwriteM:1'b1, longop_done:1'b1, regwriteW:1'b1,
                memtoregE:1'b1, writeregE:5'd0, rsD:5'd0, stl:1'b1, default:'0};
    tbl[8]  = '{memtoregE:1'b1, writeregE:5'd3, rsD:5'd3, stl:1'b1, default:'0};
    tbl[9]  = '{memtoregE:1'b1, writeregE:5'd6, rsD:5'd2, rtD:5'd6, stl:1'b1, default:'0};
    tbl[10] = '{memtoregE:1'b1, writeregE:5'd6, rsD:5'd2, rtD:5'd1, default:'0};
    tbl[11] = '{branchD:1'b1, regwriteE:1'b1, writeregE:5'd8, rsD:5'd8, br_takenD:1'b1,
                stl:1'b1, fld:1'b0, default:'0};
    tbl[12] = '{branchD:1'b1, regwriteE:1'b1, writeregE:5'd8, rsD:5'd2, br_takenD:1'b1,
                fld:1'b1, default:'0};
    tbl[13] = '{memtoregE:1'b1, writeregE:5'd3, rsD:5'd3, jumpD:1'b1, stl:1'b1, fld:1'b1, default:'0};
    tbl[14] = '{jalrD:1'b1, memtoregM:1'b1, writeregM:5'd9, rtD:5'd9, stl:1'b1, default:'0};
    tbl[15] = '{jalrD:1'b1, rsD:5'd1, fld:1'b1, default:'0};
    tbl[16] = '{branchD:1'b1, writeregE:5'd8, rsD:5'd8, default:'0};
    tbl[17] = '{longopD:1'b1, longop_busy:1'b1, regwriteD:1'b1, writeregD:5'd10, stl:1'b1, default:'0};
    tbl[18] = '{branchD:1'b1, memtoregM:1'b1, regwriteM:1'b1, writeregM:5'd5, rsD:5'd5,
                stl:1'b1, fad:1'b1, default:'0};

    // Reset
    clr();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset.pending", 0, hz.pending, 32'h0);
    chk("reset.stall_cnt", 0, 32'(hz.stall_cnt), 32'h0);
    chk("reset.stallD", 0, 32'(hz.stallD), 32'h0);

    // Combinational vector table (scoreboard empty throughout)
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      $display("vec %0d: fae=%b fbe=%b fad=%b fbd=%b stall=%b flushD=%b", i,
               hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD, hz.stallD, hz.flushD);
      chk("forwardAE", i, 32'(hz.forwardAE), 32'(tbl[i].fae));
      chk("forwardBE", i, 32'(hz.forwardBE), 32'(tbl[i].fbe));
      chk("forwardAD", i, 32'(hz.forwardAD), 32'(tbl[i].fad));
      chk("forwardBD", i, 32'(hz.forwardBD), 32'(tbl[i].fbd));
      chk("stallD", i, 32'(hz.stallD), 32'(tbl[i].stl));
      chk("stallF", i, 32'(hz.stallF), 32'(tbl[i].stl));
      chk("flushE", i, 32'(hz.flushE), 32'(tbl[i].stl));
      chk("flushD", i, 32'(hz.flushD), 32'(tbl[i].fld));
      chk("tied", i, 32'({hz.stallE, hz.stallM, hz.stallW, hz.flushF, hz.flushM, hz.flushW}), 32'h0);
      if (tbl[i].stl) exp_cnt = exp_cnt + 1'b1;
    end
    @(negedge clk);
    clr();
    #1;
    chk("table.pending", 0, hz.pending, 32'h0);
    chk("table.stall_cnt", 0, 32'(hz.stall_cnt), 32'(exp_cnt));

    // Long-op RAW: issue to x5, consumer stalls until the cycle after done
    @(negedge clk); clr(); hz.longopD = 1; hz.regwriteD = 1; hz.writeregD = 5;
    cyc(1'b0, "mul_issue");
    @(negedge clk); clr(); hz.rsD = 5; hz.regwriteD = 1; hz.writeregD = 6;
    #1 chk("raw.pending", 0, hz.pending, 32'h0000_0020);
    cyc(1'b1, "raw_stall0");
    @(negedge clk); cyc(1'b1, "raw_stall1");
    @(negedge clk); cyc(1'b1, "raw_stall2");
    @(negedge clk); hz.longop_done = 1; hz.longop_tag = 5; hz.rtE = 5;
    cyc(1'b1, "raw_done");
    chk("raw_done.forwardBE", 0, 32'(hz.forwardBE), 32'h3);
    @(negedge clk); hz.longop_done = 0;
    cyc(1'b0, "raw_release");
    chk("raw_release.pending", 0, hz.pending, 32'h0);
    chk("raw_release.stall_cnt", 0, 32'(hz.stall_cnt), 32'(exp_cnt));

    // WAW against in-flight x9
    @(negedge clk); clr(); hz.longopD = 1; hz.regwriteD = 1; hz.writeregD = 9;
    cyc(1'b0, "waw_issue");
    @(negedge clk); clr(); hz.regwriteD = 1; hz.writeregD = 9;
    cyc(1'b1, "waw_stall");
    chk("waw.pending", 0, hz.pending, 32'h0000_0200);
    @(negedge clk); clr(); hz.longop_done = 1; hz.longop_tag = 9;
    cyc(1'b0, "waw_done");
    @(negedge clk); clr();
    #1 chk("waw_cleared.pending", 0, hz.pending, 32'h0);

    // Reset with a long op in flight, then a stale completion
    @(negedge clk); clr(); hz.longopD = 1; hz.regwriteD = 1; hz.writeregD = 4;
    cyc(1'b0, "rst_issue");
    @(negedge clk); clr();
    #1 chk("rst_pre.pending", 0, hz.pending, 32'h0000_0010);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_mid.pending", 0, hz.pending, 32'h0);
    chk("rst_mid.stall_cnt", 0, 32'(hz.stall_cnt), 32'h0);
    exp_cnt = '0;
    @(negedge clk); hz.longop_done = 1; hz.longop_tag = 4;
    cyc(1'b0, "stale_done");
    @(negedge clk); clr();
    #1 chk("stale_done.pending", 0, hz.pending, 32'h0);

    // 16 stall cycles wrap a 4-bit counter back to zero
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); clr(); hz.memtoregE = 1; hz.writeregE = 3; hz.rsD = 3;
      cyc(1'b1, "wrap");
    end
    @(negedge clk); clr();
    #1;
    chk("wrap.stall_cnt", 0, 32'(hz.stall_cnt), 32'(exp_cnt));
    chk("wrap.zero", 0, 32'(hz.stall_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
